lfsr_checker: RTL and testbench

Serial receive-side checker for the 64-bit XNOR LFSR test pattern driven onto the light outputs by the pattern generator. The generator's feedback rule is b[t] = b[t-64] ^ b[t-56] ^ b[t-51] ^ b[t-33] ^ 1.
- Consumes one pattern bit per valid beat and self-synchronises to the stream from its own history.
- Declares lock after a run of correct predictions.
- Counts bit errors while locked, using a flywheel so each corrupted input bit costs exactly one error.
- Sits between an input-switch/serial source and status lights in bring-up designs.

---
 rtl/lfsr_checker.sv | 132 +++++++++++++
 tb/tb_lfsr_checker.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_checker.sv
// Purpose: serial checker that self-synchronises to the 64-bit XNOR LFSR pattern and counts bit errors.
// Latency: every output is registered and updates on the edge that samples the valid beat.
// Backpressure: none; a beat is consumed on every cycle DIN_VALID is high, and gaps are allowed.
module lfsr_checker #(
   parameter int LOCK_COUNT = 64,
   parameter int LOSS_COUNT = 8,
   parameter int ERR_W      = 16
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             CLR,
   input  logic             DIN,
   input  logic             DIN_VALID,
   output logic             LOCKED,
   output logic             ERR,
   output logic [ERR_W-1:0] ERR_COUNT
);

   typedef enum logic [1:0] {
      ST_FILL   = 2'd0,
      ST_VERIFY = 2'd1,
      ST_LOCKED = 2'd2
   } state_t;

   localparam logic [7:0]       LOCK_C    = 8'(LOCK_COUNT);
   localparam logic [7:0]       LOSS_C    = 8'(LOSS_COUNT);
   localparam logic [7:0]       FILL_LAST = 8'd63;
   localparam logic [ERR_W-1:0] ERR_MAX   = '1;
   localparam logic [ERR_W-1:0] ERR_ONE   = ERR_W'(1);

   state_t           state;
   state_t           state_nxt;
   logic [63:0]      hist;
   logic [63:0]      hist_nxt;
   // One counter is shared: fill beats in FILL, matches in VERIFY, misses in LOCKED.
   logic [7:0]       cnt;
   logic [7:0]       cnt_nxt;
   logic [7:0]       cnt_inc;
   logic             locked_nxt;
   logic             err_nxt;
   logic [ERR_W-1:0] err_count_nxt;
   logic             pred;
   logic             miss;
   logic             hist_ones;

   // The generator taps b[t-64], b[t-56], b[t-51] and b[t-33] sit at hist[63], [55], [50] and [32].
   assign pred      = ~(hist[63] ^ hist[55] ^ hist[50] ^ hist[32]);
   assign miss      = DIN != pred;
   // An all-ones history predicts 1 forever, so a stuck-high input would lock without this guard.
   assign hist_ones = &hist;
   assign cnt_inc   = cnt + 8'd1;

   // Next-state logic: the history is loaded from DIN while acquiring and from the prediction once locked.
   always_comb begin
      state_nxt     = state;
      hist_nxt      = hist;
      cnt_nxt       = cnt;
      err_nxt       = 1'b0;
      err_count_nxt = ERR_COUNT;
      if (DIN_VALID) begin
         case (state)
            ST_FILL: begin
               hist_nxt = {hist[62:0], DIN};
               if (cnt == FILL_LAST) begin
                  state_nxt = ST_VERIFY;
                  cnt_nxt   = 8'd0;
               end else begin
                  cnt_nxt = cnt_inc;
               end
            end
            ST_VERIFY: begin
               hist_nxt = {hist[62:0], DIN};
               if (miss || hist_ones) begin
                  cnt_nxt = 8'd0;
               end else if (cnt_inc == LOCK_C) begin
                  state_nxt = ST_LOCKED;
                  cnt_nxt   = 8'd0;
               end else begin
                  cnt_nxt = cnt_inc;
               end
            end
            ST_LOCKED: begin
               // Flywheel: a corrupted input never enters the history, so it costs exactly one error.
               hist_nxt = {hist[62:0], pred};
               if (miss) begin
                  err_nxt = 1'b1;
                  if (ERR_COUNT != ERR_MAX) begin
                     err_count_nxt = ERR_COUNT + ERR_ONE;
                  end
                  if (cnt_inc == LOSS_C) begin
                     state_nxt = ST_FILL;
                     cnt_nxt   = 8'd0;
                  end else begin
                     cnt_nxt = cnt_inc;
                  end
               end else begin
                  cnt_nxt = 8'd0;
               end
            end
            default: begin
               state_nxt = ST_FILL;
               cnt_nxt   = 8'd0;
            end
         endcase
      end
      // Clear wins over an increment in the same cycle.
      if (CLR) begin
         err_count_nxt = '0;
      end
      locked_nxt = (state_nxt == ST_LOCKED);
   end

   // State and output registers.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state     <= ST_FILL;
         hist      <= '0;
         cnt       <= 8'd0;
         LOCKED    <= 1'b0;
         ERR       <= 1'b0;
         ERR_COUNT <= '0;
      end else begin
         state     <= state_nxt;
         hist      <= hist_nxt;
         cnt       <= cnt_nxt;
         LOCKED    <= locked_nxt;
         ERR       <= err_nxt;
         ERR_COUNT <= err_count_nxt;
      end
   end

endmodule

// File: tb/tb_lfsr_checker.sv
// Bench for lfsr_checker: two instances (defaults, and ERR_W=4 / LOSS_COUNT=32) share one stimulus.
// Each instance is compared every cycle against a bit-history model, plus literal scenario checks.
// Stimulus: directed generator streams, then a randomized stream with gaps, flips, bursts and clears.
module tb_lfsr_checker;

   logic        CLK = 1'b0;
   logic        rst_n = 1'b0;
   logic        clr = 1'b0;
   logic        din = 1'b0;
   logic        vld = 1'b0;
   logic        locked_a, err_a, locked_b, err_b;
   logic [15:0] ec_a;
   logic [3:0]  ec_b;

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   // generator stream from generator reset; earlier bits are taken as 0
   bit gen[4000];

   // model state per instance: 0 = acquiring fill, 1 = verifying, 2 = locked
   int m_mode[2];
   int m_cnt[2];
   int m_ec[2];
   bit m_err[2];
   bit m_hist[2][64];   // [0] = bit from 64 beats ago, [63] = newest
   int p_loss[2] = '{8, 32};
   int p_emax[2] = '{65535, 15};

   // scenario bookkeeping for instance a
   int nb, rise, fall, nerr, last_err;
   bit prev_lk;

   always #5 CLK = ~CLK;

   lfsr_checker dut_a (
      .CLK(CLK), .RST_N(rst_n), .CLR(clr), .DIN(din), .DIN_VALID(vld),
      .LOCKED(locked_a), .ERR(err_a), .ERR_COUNT(ec_a)
   );

   lfsr_checker #(.LOCK_COUNT(64), .LOSS_COUNT(32), .ERR_W(4)) dut_b (
      .CLK(CLK), .RST_N(rst_n), .CLR(clr), .DIN(din), .DIN_VALID(vld),
      .LOCKED(locked_b), .ERR(err_b), .ERR_COUNT(ec_b)
   );

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset(input int i);
      m_mode[i] = 0;
      m_cnt[i]  = 0;
      m_ec[i]   = 0;
      m_err[i]  = 1'b0;
      for (int k = 0; k < 64; k++) m_hist[i][k] = 1'b0;
   endtask

   task automatic model_push(input int i, input bit b);
      for (int k = 0; k < 63; k++) m_hist[i][k] = m_hist[i][k+1];
      m_hist[i][63] = b;
   endtask

   task automatic model_step(input int i, input bit d, input bit v, input bit c);
      bit p;
      bit ones;
      m_err[i] = 1'b0;
      if (v) begin
         p = m_hist[i][0] ^ m_hist[i][8] ^ m_hist[i][13] ^ m_hist[i][31] ^ 1'b1;
         ones = 1'b1;
         for (int k = 0; k < 64; k++) if (!m_hist[i][k]) ones = 1'b0;
         if (m_mode[i] == 0) begin
            model_push(i, d);
            m_cnt[i]++;
            if (m_cnt[i] == 64) begin
               m_mode[i] = 1;
               m_cnt[i]  = 0;
            end
         end else if (m_mode[i] == 1) begin
            model_push(i, d);
            if (d == p && !ones) m_cnt[i]++;
            else m_cnt[i] = 0;
            if (m_cnt[i] == 64) begin
               m_mode[i] = 2;
               m_cnt[i]  = 0;
            end
         end else begin
            model_push(i, p);
            if (d != p) begin
               m_err[i] = 1'b1;
               if (m_ec[i] < p_emax[i]) m_ec[i]++;
               m_cnt[i]++;
               if (m_cnt[i] == p_loss[i]) begin
                  m_mode[i] = 0;
                  m_cnt[i]  = 0;
               end
            end else begin
               m_cnt[i] = 0;
            end
         end
      end
      if (c) m_ec[i] = 0;
   endtask

   // reference model advances on the same edges as the DUTs
   always @(posedge CLK or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 2; i++) model_reset(i);
      end else begin
         for (int i = 0; i < 2; i++) model_step(i, din, vld, clr);
      end
   end

   // single compare process, away from the active edge
   always @(negedge CLK) begin
      if (chk_en) begin
         chk("locked_a", locked_a, m_mode[0] == 2);
         chk("err_a", err_a, m_err[0]);
         chk("err_count_a", ec_a, m_ec[0]);
         chk("locked_b", locked_b, m_mode[1] == 2);
         chk("err_b", err_b, m_err[1]);
         chk("err_count_b", ec_b, m_ec[1]);
      end
   end

   task automatic step(input bit d, input bit v, input bit c);
      din = d;
      vld = v;
      clr = c;
      @(negedge CLK);
      #1;
      if (v) nb++;
      if (locked_a && !prev_lk) rise = nb;
      if (!locked_a && prev_lk) fall = nb;
      prev_lk = locked_a;
      if (err_a) begin
         nerr++;
         last_err = nb;
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      din = 1'b0;
      vld = 1'b0;
      clr = 1'b0;
      repeat (2) @(negedge CLK);
      rst_n = 1'b1;
      #1;
      nb = 0; rise = -1; fall = -1; nerr = 0; last_err = -1; prev_lk = 1'b0;
   endtask

   int inv_left;
   bit d_r, v_r, c_r;

   initial begin
      for (int t = 0; t < 4000; t++) begin
         gen[t] = 1'b1;
         if (t >= 64) gen[t] ^= gen[t-64];
         if (t >= 56) gen[t] ^= gen[t-56];
         if (t >= 51) gen[t] ^= gen[t-51];
         if (t >= 33) gen[t] ^= gen[t-33];
      end
      chk("gen_bit0", gen[0], 1);
      chk("gen_bit32", gen[32], 1);
      chk("gen_bit33", gen[33], 0);
      chk("gen_bit51", gen[51], 1);

      // clean continuous stream
      do_reset();
      chk("reset_locked", locked_a, 0);
      chk("reset_err", err_a, 0);
      chk("reset_count", ec_a, 0);
      chk_en = 1'b1;
      repeat (2000) step(gen[nb], 1'b1, 1'b0);
      chk("s1_lock_beat", rise, 128);
      chk("s1_err_pulses", nerr, 0);
      chk("s1_count", ec_a, 0);
      chk("s1_model_locked", m_mode[0], 2);

      // single inverted bit at beat 500
      do_reset();
      repeat (1000) step(gen[nb] ^ (nb == 499), 1'b1, 1'b0);
      chk("s2_lock_beat", rise, 128);
      chk("s2_err_pulses", nerr, 1);
      chk("s2_err_beat", last_err, 500);
      chk("s2_count", ec_a, 1);
      chk("s2_locked", locked_a, 1);

      // valid alternating 1/0
      do_reset();
      for (int c = 0; c < 4000; c++) begin
         if (c % 2 == 0) step(gen[nb], 1'b1, 1'b0);
         else step(1'($urandom), 1'b0, 1'b0);
      end
      chk("s3_lock_beat", rise, 128);
      chk("s3_err_pulses", nerr, 0);
      chk("s3_count", ec_a, 0);

      // inverted stream after lock, then restored
      do_reset();
      repeat (300) step(gen[nb], 1'b1, 1'b0);
      repeat (8) step(~gen[nb], 1'b1, 1'b0);
      chk("s4_fall_beat", fall, 308);
      chk("s4_err_pulses", nerr, 8);
      rise = -1;
      repeat (292) step(gen[nb], 1'b1, 1'b0);
      chk("s4_relock_beat", rise, 436);
      chk("s4_count", ec_a, 8);
      chk("s4_b_locked", locked_b, 1);

      // constant ones
      do_reset();
      repeat (600) step(1'b1, 1'b1, 1'b0);
      chk("s5_never_locked", rise, -1);
      chk("s5_count", ec_a, 0);

      // saturation on the narrow instance, clear during an error, async reset
      do_reset();
      repeat (200) step(gen[nb], 1'b1, 1'b0);
      chk("s6_b_locked", locked_b, 1);
      for (int k = 0; k < 20; k++) begin
         step(~gen[nb], 1'b1, k == 17);
         if (k == 16) chk("s6_saturated", ec_b, 15);
         if (k == 17) begin
            chk("s6_clear_count", ec_b, 0);
            chk("s6_clear_err", err_b, 1);
         end
      end
      chk("s6_after_clear", ec_b, 2);
      chk("s6_b_still_locked", locked_b, 1);
      repeat (10) step(gen[nb], 1'b1, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_locked_b", locked_b, 0);
      chk("async_err_b", err_b, 0);
      chk("async_count_b", ec_b, 0);
      chk("async_count_a", ec_a, 0);
      chk("async_locked_a", locked_a, 0);

      // randomized: gaps, single flips, inverted bursts, clears
      do_reset();
      inv_left = 0;
      for (int c = 0; c < 3000; c++) begin
         v_r = $urandom_range(0, 9) < 7;
         c_r = $urandom_range(0, 39) == 0;
         if (inv_left == 0 && $urandom_range(0, 299) == 0) inv_left = $urandom_range(4, 40);
         d_r = gen[nb] ^ ($urandom_range(0, 79) == 0);
         if (inv_left > 0) begin
            d_r = ~gen[nb];
            if (v_r) inv_left--;
         end
         if (!v_r) d_r = 1'($urandom);
         step(d_r, v_r, c_r);
      end

      chk_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
